bias_bank_add: RTL and testbench

//  Successor to the fixed per-layer bias constant banks. Holds NUM_GROUPS x N_adder_tree signed

---
 rtl/bias_bank_add.sv | 215 +++++++++++++++++++++
 tb/tb_bias_bank_add.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_bank_add.sv
// Runtime-loadable signed bias bank added lane-wise to accumulator vectors,
// saturated to DATA_W through a 2-stage valid/ready pipeline.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ld_valid/ld_ready load beat handshake; ld_data bias word; ld_last ends load
//   reload            request a fresh bank load (drains the pipeline first)
//   in_valid/in_ready accumulator vector handshake; in_data lanes; in_group
//   out_valid/out_ready biased, saturated vector handshake; out_data lanes
//   bank_loaded       bank holds a complete load
//   grp_err           sticky flag, an out-of-range group was accepted
module bias_bank_add #(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = 18,
    parameter int ACC_W        = 24,
    parameter int NUM_GROUPS   = 4,
    parameter int GROUP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [DATA_W-1:0]              ld_data,
    input  logic                           ld_last,
    input  logic                           reload,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_adder_tree*ACC_W-1:0]  in_data,
    input  logic [GROUP_W-1:0]             in_group,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic                           bank_loaded,
    output logic                           grp_err
);

    localparam int LANE_W = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic [GROUP_W:0]   NG_W   = (GROUP_W+1)'(NUM_GROUPS);
    localparam logic [GROUP_W-1:0] G_LAST = GROUP_W'(NUM_GROUPS - 1);
    localparam logic [LANE_W-1:0]  L_LAST = LANE_W'(N_adder_tree - 1);

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [GROUP_W-1:0] wg_q, wg_d;
    logic [LANE_W-1:0]  wl_q, wl_d;
    logic               loaded_q, loaded_d;
    logic               err_q, err_d;

    logic [DATA_W-1:0] bank_q [NUM_GROUPS][N_adder_tree];

    logic                    s1_v_q, s1_v_d;
    logic signed [SUM_W-1:0] s1_q [N_adder_tree];
    logic signed [SUM_W-1:0] s1_d [N_adder_tree];

    logic                           s2_v_q, s2_v_d;
    logic [N_adder_tree*DATA_W-1:0] s2_q, s2_d;

    logic               ld_fire, ld_end;
    logic               in_fire, adv, pipe_empty;
    logic               grp_oob;
    logic [GROUP_W-1:0] grp_sel;

    function automatic logic signed [SUM_W-1:0] add_bias(
        input logic [ACC_W-1:0]  a,
        input logic [DATA_W-1:0] b
    );
        add_bias = $signed({a[ACC_W-1], a})
                 + $signed({{(SUM_W-DATA_W){b[DATA_W-1]}}, b});
    endfunction

    function automatic logic [DATA_W-1:0] sat(
        input logic signed [SUM_W-1:0] s
    );
        if (s > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
        else if (s < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
        else                  sat = s[DATA_W-1:0];
    endfunction

    assign ld_fire    = (state_q == ST_LOAD) & ld_valid;
    assign ld_end     = ld_fire
                      & (ld_last | ((wg_q == G_LAST) & (wl_q == L_LAST)));
    // One advance signal serves both stages: stage 1 may move only
    // when stage 2 can take its contents.
    assign adv        = !s2_v_q | out_ready;
    assign in_fire    = in_valid & in_ready;
    assign pipe_empty = !s1_v_q & !s2_v_q;
    assign grp_oob    = {1'b0, in_group} >= NG_W;
    assign grp_sel    = grp_oob ? G_LAST : in_group;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:  if (ld_end)     state_d = ST_RUN;
            ST_RUN:   if (reload)     state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_d = ST_LOAD;
            default:                  state_d = ST_LOAD;
        endcase
    end

    // FSM outputs
    always_comb begin
        ld_ready = 1'b0;
        in_ready = 1'b0;
        unique case (state_q)
            ST_LOAD:  ld_ready = 1'b1;
            ST_RUN:   in_ready = !s1_v_q | adv;
            ST_DRAIN: in_ready = 1'b0;
            default:  ld_ready = 1'b0;
        endcase
    end

    // Load pointer, loaded flag and sticky error
    always_comb begin
        wg_d     = wg_q;
        wl_d     = wl_q;
        loaded_d = loaded_q;
        if (ld_end) begin
            wg_d     = '0;
            wl_d     = '0;
            loaded_d = 1'b1;
        end else if (ld_fire) begin
            if (wl_q == L_LAST) begin
                wl_d = '0;
                wg_d = wg_q + 1'b1;
            end else begin
                wl_d = wl_q + 1'b1;
            end
        end
        if ((state_q == ST_DRAIN) && pipe_empty) begin
            wg_d     = '0;
            wl_d     = '0;
            loaded_d = 1'b0;
        end
        err_d = err_q | (in_fire & grp_oob);
    end

    // Datapath: stage 1 adds, stage 2 saturates
    always_comb begin
        s1_v_d = in_fire | (s1_v_q & !adv);
        for (int i = 0; i < N_adder_tree; i++) begin
            s1_d[i] = in_fire
                    ? add_bias(in_data[ACC_W*i +: ACC_W], bank_q[grp_sel][i])
                    : s1_q[i];
        end
        s2_v_d = adv ? s1_v_q : s2_v_q;
        s2_d   = s2_q;
        if (adv && s1_v_q) begin
            for (int i = 0; i < N_adder_tree; i++) begin
                s2_d[DATA_W*i +: DATA_W] = sat(s1_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wg_q     <= '0;
            wl_q     <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s2_q     <= '0;
            for (int i = 0; i < N_adder_tree; i++) begin
                s1_q[i] <= '0;
            end
            for (int g = 0; g < NUM_GROUPS; g++) begin
                for (int i = 0; i < N_adder_tree; i++) begin
                    bank_q[g][i] <= '0;
                end
            end
        end else begin
            wg_q     <= wg_d;
            wl_q     <= wl_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            s1_v_q   <= s1_v_d;
            s2_v_q   <= s2_v_d;
            s2_q     <= s2_d;
            for (int i = 0; i < N_adder_tree; i++) begin
                s1_q[i] <= s1_d[i];
            end
            // Loads happen only in LOAD, which is entered with an
            // empty pipeline, so in-flight vectors see stable biases.
            if (ld_fire) begin
                bank_q[wg_q][wl_q] <= ld_data;
            end
        end
    end

    assign out_valid   = s2_v_q;
    assign out_data    = s2_q;
    assign bank_loaded = loaded_q;
    assign grp_err     = err_q;

endmodule

// File: tb/tb_bias_bank_add.sv
// Randomized self-checking bench for bias_bank_add: a scoreboard model
// tracks the bias bank and predicts every output vector.
module tb_bias_bank_add;

    localparam int N  = 16;
    localparam int DW = 18;
    localparam int AW = 24;
    localparam int NG = 4;
    localparam int GW = 2;
    localparam int VMAX = 2**(DW-1) - 1;
    localparam int VMIN = -(2**(DW-1));

    logic            clk = 1'b0;
    logic            rst_n, rst3_n;
    logic            ld_valid, ld_valid3, ld_ready, ld_ready3;
    logic [DW-1:0]   ld_data;
    logic            ld_last;
    logic            reload;
    logic            reload3 = 1'b0;
    logic            in_valid, in_valid3, in_ready, in_ready3;
    logic [N*AW-1:0] in_data;
    logic [GW-1:0]   in_group;
    logic            out_valid, out_valid3, out_ready;
    logic [N*DW-1:0] out_data, out_data3;
    logic            bank_loaded, bank_loaded3, grp_err, grp_err3;

    bias_bank_add #(
        .N_adder_tree(N), .DATA_W(DW), .ACC_W(AW), .NUM_GROUPS(NG)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .reload(reload),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_group(in_group),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
        .bank_loaded(bank_loaded), .grp_err(grp_err)
    );

    // Three-group instance so that group index 3 is out of range.
    bias_bank_add #(
        .N_adder_tree(N), .DATA_W(DW), .ACC_W(AW), .NUM_GROUPS(3)
    ) u_dut3 (
        .clk(clk), .rst_n(rst3_n),
        .ld_valid(ld_valid3), .ld_ready(ld_ready3),
        .ld_data(ld_data), .ld_last(ld_last), .reload(reload3),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data), .in_group(in_group),
        .out_valid(out_valid3), .out_ready(out_ready),
        .out_data(out_data3),
        .bank_loaded(bank_loaded3), .grp_err(grp_err3)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [511:0] got,
                         input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int              bias_m [NG][N];
    int              k_m;
    int              n_out;
    logic [N*DW-1:0] expq [$];
    logic            held_v;
    logic [N*DW-1:0] held_d;
    logic [DW-1:0]   ldw [64];

    function automatic logic [N*DW-1:0] ref_vec(logic [N*AW-1:0] d,
                                                 logic [GW-1:0] g);
        logic [N*DW-1:0] r;
        longint          s;
        int              gi;
        gi = (int'(g) >= NG) ? NG - 1 : int'(g);
        for (int i = 0; i < N; i++) begin
            s = longint'($signed(d[AW*i +: AW])) + longint'(bias_m[gi][i]);
            if (s > VMAX) s = VMAX;
            if (s < VMIN) s = VMIN;
            r[DW*i +: DW] = DW'(s);
        end
        return r;
    endfunction

    function automatic logic [N*AW-1:0] fill(int v);
        logic [N*AW-1:0] d;
        for (int i = 0; i < N; i++) d[AW*i +: AW] = AW'(v);
        return d;
    endfunction

    function automatic logic [N*DW-1:0] ramp(int base);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[DW*i +: DW] = DW'(base + i);
        return r;
    endfunction

    function automatic logic [N*AW-1:0] rvec();
        logic [N*AW-1:0] d;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1)
                d[AW*i +: AW] = AW'($urandom);
            else
                d[AW*i +: AW] = AW'(int'($urandom_range(0, 400)) - 200);
        end
        return d;
    endfunction

    // Scoreboard: sampled mid-cycle, when the coming edge's
    // handshakes are already determined.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            k_m    = 0;
            held_v = 1'b0;
            for (int g = 0; g < NG; g++)
                for (int i = 0; i < N; i++) bias_m[g][i] = 0;
        end else begin
            if (ld_valid && ld_ready) begin
                bias_m[k_m / N][k_m % N] = int'($signed(ld_data));
                if (ld_last || k_m == NG*N - 1) k_m = 0;
                else                            k_m++;
            end
            if (held_v)
                check("hold", 512'({out_valid, out_data}),
                      512'({1'b1, held_d}));
            if (out_valid && out_ready) begin
                n_out++;
                held_v = 1'b0;
                if (expq.size() == 0)
                    check("spurious_out", 512'(1), 512'(0));
                else
                    check("out_data", 512'(out_data),
                          512'(expq.pop_front()));
            end else if (out_valid) begin
                held_v = 1'b1;
                held_d = out_data;
            end else begin
                held_v = 1'b0;
            end
            if (in_valid && in_ready)
                expq.push_back(ref_vec(in_data, in_group));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_n(input int first, input int n, input bit early);
        for (int k = first; k < first + n; k++) begin
            ld_valid = 1'b1;
            ld_data  = ldw[k];
            ld_last  = early && (k == first + n - 1);
            cyc(1);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send(input logic [N*AW-1:0] d, input logic [GW-1:0] g);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_group = g;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 512'(0), 512'(1));
    endtask

    task automatic do_reload();
        reload = 1'b1;
        cyc(1);
        reload = 1'b0;
        for (int t = 0; t < 50 && !ld_ready; t++) cyc(1);
        check("reload_ld_ready", 512'(ld_ready), 512'(1));
        check("reload_unloaded", 512'(bank_loaded), 512'(0));
    endtask

    task automatic wait_out();
        for (int t = 0; t < 50 && !out_valid; t++) cyc(1);
        check("out_timeout", 512'(out_valid), 512'(1));
    endtask

    task automatic wait_out3();
        for (int t = 0; t < 50 && !out_valid3; t++) cyc(1);
        check("out3_timeout", 512'(out_valid3), 512'(1));
    endtask

    task automatic send3(input logic [N*AW-1:0] d, input logic [GW-1:0] g);
        bit ok;
        ok        = 1'b0;
        in_valid3 = 1'b1;
        in_data   = d;
        in_group  = g;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready3;
        end
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        if (!ok) check("send3_timeout", 512'(0), 512'(1));
    endtask

    initial begin
        int              base;
        logic [N*AW-1:0] d;

        rst_n = 1'b0; rst3_n = 1'b0;
        ld_valid = 1'b0; ld_valid3 = 1'b0; ld_data = '0; ld_last = 1'b0;
        reload = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0;
        in_data = '0; in_group = '0; out_ready = 1'b1;
        n_out = 0; held_v = 1'b0;
        cyc(2);
        check("rst_ld_ready", 512'(ld_ready), 512'(1));
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_out_data", 512'(out_data), 512'(0));
        check("rst_loaded", 512'(bank_loaded), 512'(0));
        check("rst_grp_err", 512'(grp_err), 512'(0));
        rst_n = 1'b1;

        // Full load with 16*g+i, then a fixed vector
        for (int k = 0; k < 64; k++) ldw[k] = DW'(16 * (k / 16) + k % 16);
        load_n(0, 63, 1'b0);
        check("loaded_before_last", 512'(bank_loaded), 512'(0));
        load_n(63, 1, 1'b0);
        check("loaded_after_last", 512'(bank_loaded), 512'(1));
        check("run_ld_ready", 512'(ld_ready), 512'(0));
        check("run_in_ready", 512'(in_ready), 512'(1));
        send(fill(100), 2'd2);
        check("lat_early", 512'(out_valid), 512'(0));
        cyc(1);
        check("lat_valid", 512'(out_valid), 512'(1));
        check("lat_data", 512'(out_data), 512'(ramp(132)));
        cyc(1);

        // Saturation at both rails
        do_reload();
        ldw[0] = 18'h1FFFF;
        ldw[1] = 18'h20000;
        load_n(0, 2, 1'b1);
        check("sat_loaded", 512'(bank_loaded), 512'(1));
        d = rvec();
        d[AW-1:0]    = AW'(5);
        d[2*AW-1:AW] = AW'(-1);
        send(d, 2'd0);
        wait_out();
        check("sat_max", 512'(out_data[DW-1:0]), 512'(18'h1FFFF));
        check("sat_min", 512'(out_data[2*DW-1:DW]), 512'(18'h20000));
        cyc(1);

        // Early end on word 3; other groups keep prior biases
        do_reload();
        for (int k = 0; k < 4; k++) ldw[k] = DW'($urandom);
        load_n(0, 4, 1'b1);
        check("early_loaded", 512'(bank_loaded), 512'(1));
        check("early_in_ready", 512'(in_ready), 512'(1));
        for (int g = 0; g < NG; g++) send(rvec(), GW'(g));
        cyc(4);

        // Back-to-back stream with out_ready toggling 1010..
        base = n_out;
        fork
            begin
                for (int v = 0; v < 8; v++)
                    send(rvec(), GW'($urandom_range(0, NG - 1)));
            end
            begin
                for (int t = 0; t < 40; t++) begin
                    out_ready = (t % 2 == 0);
                    cyc(1);
                end
            end
        join
        out_ready = 1'b1;
        cyc(5);
        check("stream_count", 512'(n_out - base), 512'(8));
        check("stream_drained", 512'(expq.size()), 512'(0));

        // Reload with two vectors in flight, one coinciding with reload
        out_ready = 1'b0;
        send(rvec(), 2'd1);
        reload = 1'b1;
        send(rvec(), 2'd3);
        reload = 1'b0;
        check("drain_in_ready", 512'(in_ready), 512'(0));
        check("drain_ld_ready", 512'(ld_ready), 512'(0));
        cyc(3);
        check("drain_stalled", 512'(expq.size()), 512'(2));
        out_ready = 1'b1;
        for (int t = 0; t < 50 && !ld_ready; t++) cyc(1);
        check("drain_to_load", 512'(ld_ready), 512'(1));
        check("drain_delivered", 512'(expq.size()), 512'(0));
        check("drain_unloaded", 512'(bank_loaded), 512'(0));

        // Random full load, then reset mid-stream
        for (int k = 0; k < 64; k++) ldw[k] = DW'($urandom);
        load_n(0, 64, 1'b0);
        send(rvec(), 2'd1);
        wait_out();
        cyc(1);
        out_ready = 1'b0;
        send(rvec(), 2'd0);
        send(rvec(), 2'd2);
        rst_n = 1'b0;
        cyc(1);
        check("mid_rst_out_valid", 512'(out_valid), 512'(0));
        check("mid_rst_loaded", 512'(bank_loaded), 512'(0));
        check("mid_rst_ld_ready", 512'(ld_ready), 512'(1));
        check("mid_rst_in_ready", 512'(in_ready), 512'(0));
        rst_n = 1'b1;
        out_ready = 1'b1;
        ldw[0] = DW'($urandom);
        load_n(0, 1, 1'b1);
        send(rvec(), 2'd3);
        send(rvec(), 2'd0);
        cyc(4);
        check("post_rst_drained", 512'(expq.size()), 512'(0));
        check("main_grp_err", 512'(grp_err), 512'(0));

        // Out-of-range group on the three-group instance
        rst3_n = 1'b1;
        for (int k = 0; k < 48; k++) begin
            ld_valid3 = 1'b1;
            ld_data   = DW'(1000 + k);
            cyc(1);
        end
        ld_valid3 = 1'b0;
        check("g3_loaded", 512'(bank_loaded3), 512'(1));
        send3(fill(7), 2'd3);
        wait_out3();
        check("g3_clamp_data", 512'(out_data3), 512'(ramp(1039)));
        check("g3_err_set", 512'(grp_err3), 512'(1));
        cyc(1);
        send3(fill(7), 2'd0);
        wait_out3();
        check("g3_grp0_data", 512'(out_data3), 512'(ramp(1007)));
        check("g3_err_sticky", 512'(grp_err3), 512'(1));
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
